// File: rtl/krnl_vadd_rtl_burst_packer.sv
// rtl/krnl_vadd_rtl_burst_packer.sv - FIFO-buffered AXI-Stream burst packer with run framing (optional stats: KRNL_VADD_PACKER_STATS_EN)
module krnl_vadd_rtl_burst_packer #(
  parameter int C_DATA_WIDTH  = 32,
  parameter int C_FIFO_DEPTH  = 16,
  parameter int C_BURST_LEN   = 8,
  parameter int C_COUNT_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     ctrl_start,
  input  logic [C_COUNT_WIDTH-1:0] ctrl_beats,
  output logic                     ctrl_done,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic [C_DATA_WIDTH-1:0]  s_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [C_DATA_WIDTH-1:0]  m_tdata,
  output logic                     m_tlast
`ifdef KRNL_VADD_PACKER_STATS_EN
  ,
  output logic [31:0]              stat_stall_cycles
`endif
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int BW = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [C_DATA_WIDTH-1:0]  mem [C_FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic [C_COUNT_WIDTH-1:0] in_rem, out_rem;
  logic [BW-1:0]            burst_cnt;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop, start_run, burst_end, final_beat;

  // Full/empty come from the registered occupancy, so a same-cycle pop never reopens s_tready.
  assign fifo_full  = (count == (AW+1)'(C_FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = s_tvalid & s_tready;
  assign pop        = m_tvalid & m_tready;
  assign burst_end  = (burst_cnt == BW'(C_BURST_LEN - 1));
  assign final_beat = (out_rem == C_COUNT_WIDTH'(1));

  // Head of the FIFO drives the output; zero while empty so idle outputs read as 0.
  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_empty ? '0 : mem[rd_ptr];
  assign m_tlast  = m_tvalid & (burst_end | final_beat);

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and control outputs.
  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    ctrl_done = 1'b0;
    start_run = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_start) begin
          if (ctrl_beats != '0) begin
            state_nxt = RUN;
            start_run = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        s_tready = !fifo_full;
        if (s_tvalid && !fifo_full && in_rem == C_COUNT_WIDTH'(1))
          state_nxt = (pop && final_beat) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (pop && final_beat) state_nxt = DONE;
      end
      DONE: begin
        ctrl_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Run counters: remaining beats in/out (saturating at 0) and position within the burst.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_rem    <= '0;
      out_rem   <= '0;
      burst_cnt <= '0;
    end else if (start_run) begin
      in_rem    <= ctrl_beats;
      out_rem   <= ctrl_beats;
      burst_cnt <= '0;
    end else begin
      if (push && in_rem != '0) in_rem <= in_rem - 1'b1;
      if (pop) begin
        if (out_rem != '0) out_rem <= out_rem - 1'b1;
        burst_cnt <= m_tlast ? '0 : burst_cnt + 1'b1;
      end
    end
  end

`ifdef KRNL_VADD_PACKER_STATS_EN
  // Downstream back-pressure counter for the current run; holds after completion.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_stall_cycles <= '0;
    end else if (start_run) begin
      stat_stall_cycles <= '0;
    end else if ((state == RUN || state == DRAIN) && m_tvalid && !m_tready &&
                 stat_stall_cycles != '1) begin
      stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_krnl_vadd_rtl_burst_packer.sv
// tb/tb_krnl_vadd_rtl_burst_packer.sv - scoreboard testbench for krnl_vadd_rtl_burst_packer
module tb_krnl_vadd_rtl_burst_packer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BL    = 8;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_start;
  logic [CW-1:0] ctrl_beats;
  logic          ctrl_done;
  logic          s_tvalid, s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
`ifdef KRNL_VADD_PACKER_STATS_EN
  logic [31:0]   stat_stall_cycles;
`endif

  krnl_vadd_rtl_burst_packer #(
    .C_DATA_WIDTH(DW), .C_FIFO_DEPTH(DEPTH), .C_BURST_LEN(BL), .C_COUNT_WIDTH(CW)
  ) dut (
    .aclk(clk), .areset(rst),
    .ctrl_start(ctrl_start), .ctrl_beats(ctrl_beats), .ctrl_done(ctrl_done),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
`ifdef KRNL_VADD_PACKER_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t expq[$];
  int tests = 0, fails = 0;
  int cyc = 0;
  int run_beats = 0, in_idx = 0;
  int acc_cnt = 0, out_cnt = 0, done_cnt = 0;
  int last_hs_cyc = -1, done_cyc = -1, start_cyc = 0;
  int sv_seen = 0, mv_seen = 0;
  int ready_mode = 0, sv_pct = 100;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected beats on output handshakes, pushes model beats on input handshakes.
  always @(negedge clk) begin
    beat_t e, nb;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_d);
        check("hold_last", m_tlast, prev_l);
      end
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = expq.pop_front();
          check("out_data", m_tdata, e.d);
          check("out_last", m_tlast, e.l);
        end
        out_cnt++;
        last_hs_cyc = cyc;
      end
      if (s_tvalid && s_tready) begin
        nb.d = s_tdata;
        nb.l = ((in_idx % BL) == BL - 1) || (in_idx == run_beats - 1);
        expq.push_back(nb);
        in_idx++;
        acc_cnt++;
      end
      if (ctrl_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (s_tready) sv_seen++;
      if (m_tvalid) mv_seen++;
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    s_tvalid = ($urandom_range(99) < sv_pct);
    s_tdata  = $urandom;
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = $urandom_range(1);
      2:       m_tready = (cyc > start_cyc + 40);
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic clear_model(input int b);
    expq.delete();
    run_beats = b; in_idx = 0; acc_cnt = 0; out_cnt = 0; done_cnt = 0;
    done_cyc = -1; last_hs_cyc = -1; sv_seen = 0; mv_seen = 0;
  endtask

  task automatic run_test(input int b, input int rmode, input int svp, input bit mid_start);
    int to;
    clear_model(b);
    ready_mode = rmode;
    sv_pct     = svp;
    step();
    ctrl_start = 1'b1;
    ctrl_beats = CW'(b);
    start_cyc  = cyc;
    step();
    ctrl_start = 1'b0;
    ctrl_beats = $urandom;
    to = 0;
    while (done_cnt == 0 && to < 2000) begin
      step();
      ctrl_start = (mid_start && to == 6);
      if (ctrl_start) ctrl_beats = 3;
      if (rmode == 2 && cyc == start_cyc + 41) begin
        check("stall_fill", acc_cnt, DEPTH);
        check("full_blocks", s_tready, 0);
      end
      to++;
    end
    check("done_timeout", (to < 2000), 1);
    repeat (4) step();
    check("done_pulses", done_cnt, 1);
    check("beats_in", acc_cnt, b);
    check("beats_out", out_cnt, b);
    check("queue_empty", expq.size(), 0);
    if (b == 0) begin
      check("zero_done_cyc", done_cyc, start_cyc + 1);
      check("zero_s_tready", sv_seen, 0);
      check("zero_m_tvalid", mv_seen, 0);
    end else begin
      check("done_cyc", done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic reset_test();
    int to;
    clear_model(20);
    ready_mode = 3;
    sv_pct     = 100;
    step();
    ctrl_start = 1'b1;
    ctrl_beats = 20;
    step();
    ctrl_start = 1'b0;
    to = 0;
    while (acc_cnt < 5 && to < 100) begin
      step();
      to++;
    end
    check("rst_wait", acc_cnt, 5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_done", ctrl_done, 0);
    step();
    step();
    rst = 1'b0;
    clear_model(0);
    repeat (6) step();
    check("rst_no_done", done_cnt, 0);
    check("rst_no_out", mv_seen, 0);
  endtask

  initial begin
    rst        = 1'b1;
    ctrl_start = 1'b0;
    ctrl_beats = '0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    m_tready   = 1'b0;
    #12;
    check("reset_done", ctrl_done, 0);
    check("reset_s_tready", s_tready, 0);
    check("reset_m_tvalid", m_tvalid, 0);
    check("reset_m_tlast", m_tlast, 0);
    check("reset_m_tdata", m_tdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_test(16, 0, 100, 1'b0);
    run_test(11, 0, 100, 1'b0);
    run_test(32, 2, 100, 1'b0);
`ifdef KRNL_VADD_PACKER_STATS_EN
    check("stat_stall", stat_stall_cycles, 39);
`endif
    run_test(0, 0, 100, 1'b0);
    reset_test();
    run_test(4, 0, 100, 1'b0);
    run_test(20, 0, 100, 1'b1);
    for (int i = 0; i < 6; i++)
      run_test($urandom_range(1, 40), 1, $urandom_range(30, 100), 1'b0);
    run_test(1, 1, 100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
